// File: rtl/wsignal_pkg.sv
// Shared types and limits for the register-file write-strobe generator.
package wsignal_pkg;

    typedef enum logic [1:0] {
        ARM_WAIT = 2'd0,
        IDLE     = 2'd1,
        PULSE    = 2'd2
    } state_t;

    localparam int PULSE_CYCLES_MIN = 1;
    localparam int PULSE_CYCLES_MAX = 255;

endpackage

// File: rtl/wsignal_if.sv
// Enable request from the control unit and write strobe toward the register file.
interface wsignal_if;

    logic WSIGNAL_En;
    logic WSIGNAL_RegFile_Write;

    modport master (
        output WSIGNAL_En,
        input  WSIGNAL_RegFile_Write
    );

    modport slave (
        input  WSIGNAL_En,
        output WSIGNAL_RegFile_Write
    );

endinterface

// File: rtl/wsignal.sv
// Turns a level enable into exactly one registered write pulse of PULSE_CYCLES
// cycles per low-to-high episode of the enable.
module wsignal
    import wsignal_pkg::*;
#(
    parameter int PULSE_CYCLES = 1
) (
    input  logic      WSIGNAL_Clk,
    input  logic      WSIGNAL_Reset,
    wsignal_if.slave  bus
);

    localparam int CNT_W = $clog2(PULSE_CYCLES + 1);

    if (PULSE_CYCLES < PULSE_CYCLES_MIN || PULSE_CYCLES > PULSE_CYCLES_MAX) begin : g_bad_param
        $fatal(1, "wsignal: PULSE_CYCLES=%0d outside legal range", PULSE_CYCLES);
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;

    // ARM_WAIT doubles as the edge detector: the enable must be seen low before IDLE can fire.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARM_WAIT: begin
                if (!bus.WSIGNAL_En) state_d = IDLE;
            end
            IDLE: begin
                if (bus.WSIGNAL_En) begin
                    state_d = PULSE;
                    cnt_d   = CNT_W'(PULSE_CYCLES - 1);
                end
            end
            PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = bus.WSIGNAL_En ? ARM_WAIT : IDLE;
                end
            end
            default: begin
                state_d = ARM_WAIT;
                cnt_d   = '0;
            end
        endcase
        write_d = (state_d == PULSE);
    end

    always_ff @(posedge WSIGNAL_Clk or posedge WSIGNAL_Reset) begin
        if (WSIGNAL_Reset) begin
            state_q <= ARM_WAIT;
            cnt_q   <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
        end
    end

    assign bus.WSIGNAL_RegFile_Write = write_q;

endmodule

// File: tb/tb_wsignal.sv
// Directed bench for wsignal: one instance with PULSE_CYCLES=1 and one with 4.
module tb_wsignal;
    import wsignal_pkg::*;

    typedef struct {
        logic en;
        logic exp_write;
    } vec_t;

    logic clk = 1'b0;
    logic rst1;
    logic rst4;

    int pass_count  = 0;
    int check_count = 0;

    vec_t vec1 [17];
    vec_t vec4 [13];

    always #5 clk = ~clk;

    wsignal_if bus1 ();
    wsignal_if bus4 ();

    wsignal #(.PULSE_CYCLES(1)) dut1 (
        .WSIGNAL_Clk   (clk),
        .WSIGNAL_Reset (rst1),
        .bus           (bus1)
    );

    wsignal #(.PULSE_CYCLES(4)) dut4 (
        .WSIGNAL_Clk   (clk),
        .WSIGNAL_Reset (rst4),
        .bus           (bus4)
    );

    task automatic checkOutput(input string name, input logic [1:0] actual, input logic [1:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Called at a falling edge: drive enables, let one rising edge pass, return at the next falling edge.
    task automatic applyStimulus(input logic en1, input logic en4);
        bus1.WSIGNAL_En = en1;
        bus4.WSIGNAL_En = en4;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst1 = 1'b1;
        rst4 = 1'b1;
        bus1.WSIGNAL_En = 1'b1;
        bus4.WSIGNAL_En = 1'b1;

        vec1 = '{
            '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b0},
            '{1'b0, 1'b0},
            '{1'b1, 1'b1}, '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b0},
            '{1'b0, 1'b0}, '{1'b0, 1'b0}, '{1'b0, 1'b0},
            '{1'b1, 1'b1}, '{1'b0, 1'b0}, '{1'b1, 1'b1}, '{1'b0, 1'b0}
        };
        vec4 = '{
            '{1'b0, 1'b0},
            '{1'b1, 1'b1}, '{1'b0, 1'b1}, '{1'b1, 1'b1}, '{1'b0, 1'b1},
            '{1'b0, 1'b0}, '{1'b0, 1'b0},
            '{1'b1, 1'b1}, '{1'b1, 1'b1}, '{1'b1, 1'b1}, '{1'b1, 1'b1},
            '{1'b1, 1'b0}, '{1'b0, 1'b0}
        };

        @(negedge clk);
        checkOutput("reset_c0_p1", {1'b0, bus1.WSIGNAL_RegFile_Write}, 2'b00);
        checkOutput("reset_c0_p4", {1'b0, bus4.WSIGNAL_RegFile_Write}, 2'b00);
        applyStimulus(1'b1, 1'b1);
        checkOutput("reset_c1_p1", {1'b0, bus1.WSIGNAL_RegFile_Write}, 2'b00);
        checkOutput("reset_c1_p4", {1'b0, bus4.WSIGNAL_RegFile_Write}, 2'b00);

        rst1 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vec1[i].en, 1'b0);
            checkOutput($sformatf("p1_vec%0d", i), {1'b0, bus1.WSIGNAL_RegFile_Write}, {1'b0, vec1[i].exp_write});
        end

        // Illegal encoding injected while IDLE with En high: must recover to ARM_WAIT, not fire.
        force dut1.state_q = state_t'(2'd3);
        bus1.WSIGNAL_En = 1'b1;
        #1;
        release dut1.state_q;
        @(posedge clk);
        @(negedge clk);
        checkOutput("illegal_state", dut1.state_q, 2'd0);
        checkOutput("illegal_strobe", {1'b0, bus1.WSIGNAL_RegFile_Write}, 2'b00);
        applyStimulus(1'b1, 1'b0);
        checkOutput("illegal_no_fire", {1'b0, bus1.WSIGNAL_RegFile_Write}, 2'b00);

        rst4 = 1'b0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b0, vec4[i].en);
            checkOutput($sformatf("p4_vec%0d", i), {1'b0, bus4.WSIGNAL_RegFile_Write}, {1'b0, vec4[i].exp_write});
        end

        applyStimulus(1'b0, 1'b1);
        checkOutput("p4_pre_reset", {1'b0, bus4.WSIGNAL_RegFile_Write}, 2'b01);
        bus4.WSIGNAL_En = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("p4_mid_pulse", {1'b0, bus4.WSIGNAL_RegFile_Write}, 2'b01);
        rst4 = 1'b1;
        #1;
        checkOutput("p4_async_reset", {1'b0, bus4.WSIGNAL_RegFile_Write}, 2'b00);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("p4_reset_held", {1'b0, bus4.WSIGNAL_RegFile_Write}, 2'b00);
        rst4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("p4_unarmed%0d", i), {1'b0, bus4.WSIGNAL_RegFile_Write}, 2'b00);
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("p4_arm", {1'b0, bus4.WSIGNAL_RegFile_Write}, 2'b00);
        applyStimulus(1'b0, 1'b1);
        checkOutput("p4_refire", {1'b0, bus4.WSIGNAL_RegFile_Write}, 2'b01);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/wsignal.md
# wsignal

Register-file write-strobe generator for the multi-cycle RISC-V core. It converts a level-type enable from the control unit into a clean, fixed-length, registered write pulse for the register file. A single enable assertion, however long, produces exactly one pulse, so a register is written once per instruction. It sits between the control FSM and the register file write port.

## Interface
- PULSE_CYCLES, default 1: number of clock cycles the write strobe stays high per trigger; legal range 1–255.
- WSIGNAL_Clk  input  1  system clock (50 MHz); all state updates on its rising edge.
- WSIGNAL_Reset  input  1  reset; one clock, reset is asynchronous and active-high.
- WSIGNAL_En  input  1  write-enable request level from the control unit; sampled on rising edges only.
- WSIGNAL_RegFile_Write  output  1  register-file write strobe; driven directly from a flip-flop, glitch-free.

## Operation
- Three-state FSM:
  - ARM_WAIT: strobe 0; waiting for En to be seen low.
  - IDLE: strobe 0; armed.
  - PULSE: strobe 1.
- Down-counter cnt, width $clog2(PULSE_CYCLES+1), is loaded on entry to PULSE.
- Transitions, evaluated at each rising edge with the sampled En:
  - ARM_WAIT: En=0 -> IDLE; else stay.
  - IDLE: En=1 -> PULSE with cnt=PULSE_CYCLES-1; else stay.
  - PULSE: cnt≠0 -> decrement, stay. cnt=0 -> IDLE if En=0, else ARM_WAIT.
- Output is registered: WSIGNAL_RegFile_Write=1 exactly while the state register holds PULSE.
- Deassertion of En during PULSE does not shorten the pulse.
- A re-assertion of En during PULSE or ARM_WAIT is ignored. No queuing; one pulse per low-to-high episode.
- En high continuously from reset release does not fire until En has been low for at least one sampled edge.

## Timing
- Reset (asynchronous assert, any time): state=ARM_WAIT, cnt=0, WSIGNAL_RegFile_Write=0 immediately, without waiting for a clock edge.
- Reset mid-pulse aborts the pulse at once. After release, the block must see En=0 before it can fire again.
- Release is synchronous in effect: the first state update happens at the first rising edge with Reset low.
- Latency: En sampled 1 at edge N in IDLE -> strobe high from edge N until edge N+PULSE_CYCLES, i.e. exactly PULSE_CYCLES full cycles.
- Minimum spacing between pulses:
  - PULSE_CYCLES+1 edges if En drops during the pulse.
  - Otherwise PULSE_CYCLES + (edges in ARM_WAIT) + 1.
- En is required to be stable around the rising edge. The control unit changes it on the falling edge.
- No combinational path from any input to the output.

## Structure
- Shared package wsignal_pkg holds:
  - the state enum (ARM_WAIT=2'd0, IDLE=2'd1, PULSE=2'd2; 2'd3 is illegal and recovers to ARM_WAIT with strobe 0);
  - the PULSE_CYCLES limits (MIN=1, MAX=255).
- Parameter legality is checked at elaboration: an out-of-range value is a fatal error.
- Single flat module; no sub-module. The edge/arming logic is the FSM itself.

## Test plan
- Reset then arm: Reset=1 for 2 cycles with En=1 -> strobe 0 throughout. Release with En=1 held for 4 edges -> strobe stays 0 (not armed).
- Basic pulse, PULSE_CYCLES=1: En=0 at edge 1, En=1 set at the falling edge, held for 5 rising edges -> strobe high exactly one cycle after the first sampling edge, then 0 for the remaining 4 edges. Drop En, wait 3 edges -> strobe 0.
- Retrigger: En 1 (1 cycle), 0 (1 cycle), 1 (1 cycle) -> two separate 1-cycle strobes, 2 edges apart.
- Long pulse, PULSE_CYCLES=4: En high for a single cycle -> strobe high exactly 4 cycles. A second En pulse during cycle 2 -> ignored, total 4 high cycles.
- Async reset mid-pulse, PULSE_CYCLES=4: assert Reset between edges in cycle 2 -> strobe falls without a clock edge. After release with En=1 -> no strobe until En goes 0 then 1.
- Illegal state: force state=2'd3 -> next edge enters ARM_WAIT, strobe 0.
